ram1p1rwbe_arbctl: RTL and testbench
====================================

# ram1p1rwbe_arbctl

Arbitrating controller for one `ram1p1rwbe` instance. It shares the single read/write port between two requesters, A and B, using round-robin priority and a valid/ready handshake. It returns read data through a response channel one cycle after acceptance. After reset it optionally runs a sequencer that clears every RAM word to zero before granting any request. It sits between cache-side or bus-side requesters and the SRAM, and drives the SRAM's ce/addr/din/we/bwe pins directly.

## Interface
Parameters:
- `DEPTH`, 64, number of RAM words; power of two, ≥2.
- `WIDTH`, 64, bits per word; byte-enable width is BW = (WIDTH-1)/8+1.
- `INIT_CLEAR`, 1, 1 = zero-fill the RAM after reset; 0 = go straight to RUN.

Ports (x ∈ {A,B}, one independent set per requester):
- `clk`  in  1  single clock; all state updates on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `xReqValid`  in  1  request present.
- `xReqReady`  out  1  request accepted this cycle.
- `xReqWrite`  in  1  1 = write, 0 = read.
- `xReqAddr`  in  $clog2(DEPTH)  word address.
- `xReqData`  in  WIDTH  write data.
- `xReqBwe`  in  BW  byte write enables.
- `xRspValid`  out  1  read data valid, one-cycle pulse.
- `xRspData`  out  WIDTH  read data.
- `InitDone`  out  1  high once RUN is entered.
- `ram_ce`, `ram_we`  out  1  SRAM chip/write enable.
- `ram_addr`  out  $clog2(DEPTH)  SRAM address.
- `ram_din`  out  WIDTH  SRAM write data.
- `ram_bwe`  out  BW  SRAM byte enables.
- `ram_dout`  in  WIDTH  SRAM read data, valid the cycle after a ce edge.

## Operation
- States: INIT and RUN.
  - Reset enters INIT if INIT_CLEAR=1, else RUN.
- INIT:
  - Clear counter ClrCnt starts at 0.
  - Each cycle drives ram_ce=1, ram_we=1, ram_addr=ClrCnt, ram_din=0, ram_bwe=all ones.
  - ClrCnt increments each cycle.
  - On the edge where ClrCnt==DEPTH-1, go to RUN. The counter does not wrap further.
  - Both ReqReady outputs are 0 in INIT. Requests wait; they are not dropped.
- RUN arbitration:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not granted most recently wins.
  - LastGnt pointer resets to B, so A wins the first tie.
  - LastGnt updates only on a grant.
- Grant outputs:
  - xReqReady = grant_x, combinational from the Valid inputs and LastGnt.
  - ram_ce = grant to either requester.
  - ram_we, ram_addr, ram_din and ram_bwe are muxed from the granted requester.
  - When idle: ram_ce=0, ram_we=0, ram_bwe=0; ram_addr and ram_din hold 0.
- Handshake: a requester holds Valid and all request fields stable until it sees Ready. Deasserting Valid before Ready is illegal.
- Response:
  - An accepted read sets a registered flag RspPend_x.
  - Next cycle, xRspValid=1 and xRspData=ram_dout.
  - RspData for the non-pending requester is 0.
  - Writes produce no response.
  - Responses cannot be backpressured.
- Read-after-write to the same address on consecutive grants returns the new data (RAM write-then-registered-address read).
- Partial writes update only the enabled bytes. The RAM handles the MSB remainder byte when WIDTH%8≠0.

## Timing
- Reset values:
  - state = INIT (or RUN), ClrCnt=0, LastGnt=B.
  - RspPend=0, so both RspValid=0 and RspData=0.
  - InitDone=0 (1 if INIT_CLEAR=0).
  - ram_ce=0 while resetn is low.
- Init duration: DEPTH cycles of writes; the first grant is possible in cycle DEPTH after reset deassertion. InitDone is registered and rises in the same cycle.
- Throughput: one access per cycle; back-to-back grants are allowed. Under constant contention, A and B alternate.
- Read latency: accept at edge N, RspValid high during the cycle after edge N. Exactly one pulse per read.
- Reset asserted mid-operation:
  - Immediately drops Ready, RspValid and ram_ce.
  - Any pending response is discarded.
  - INIT restarts from address 0 on deassertion.
- Reset in the middle of INIT restarts the clear from address 0.

## Test plan
- Init sweep (DEPTH=64, INIT_CLEAR=1): after reset, check ram_we=1 at addresses 0..63 with din=0 on consecutive cycles. Check InitDone rises in cycle 64. A read of address 5 returns 0.
- Single requester: A writes 0x1122334455667788 with bwe=0xFF to address 3, then reads address 3 → ARspValid one cycle after accept with that data; BRspValid stays 0.
- Byte enables: write 0xFF…FF to address 7, then write 0 with bwe=0x0F → read returns 0xFFFFFFFF00000000.
- Contention: A and B both hold reads of addresses 1 and 2 → A granted first, B next cycle. Six simultaneous requests each → grants alternate A,B,A,B,A,B.
- Handshake stall: B asserts a valid write during INIT → BReqReady=0 until cycle 64, then accepted; the write lands in the RAM.
- Reset mid-op: pulse resetn low for 1 cycle right after an A read is accepted → no ARspValid, INIT restarts at address 0, and the earlier data is cleared to 0.

Source files
------------

// File: rtl/ram1p1rwbe_arbctl.sv
// Two-requester arbitrating controller for a single-port byte-write-enabled SRAM.
// Optionally zero-fills the RAM after reset, then grants one access per cycle
// round-robin between requesters A and B and returns read data one cycle later.
//
// Handshake: a request transfers on a rising edge where xReqValid && xReqReady.
// The requester holds Valid and every request field stable until it sees Ready;
// Ready is combinational from both Valid inputs and the last-grant pointer.
// Responses are single-cycle pulses and cannot be backpressured.
module ram1p1rwbe_arbctl #(
    parameter int DEPTH      = 64,
    parameter int WIDTH      = 64,
    parameter int INIT_CLEAR = 1,
    localparam int AW        = $clog2(DEPTH),
    localparam int BW        = (WIDTH - 1) / 8 + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             AReqValid,
    output logic             AReqReady,
    input  logic             AReqWrite,
    input  logic [AW-1:0]    AReqAddr,
    input  logic [WIDTH-1:0] AReqData,
    input  logic [BW-1:0]    AReqBwe,
    output logic             ARspValid,
    output logic [WIDTH-1:0] ARspData,
    input  logic             BReqValid,
    output logic             BReqReady,
    input  logic             BReqWrite,
    input  logic [AW-1:0]    BReqAddr,
    input  logic [WIDTH-1:0] BReqData,
    input  logic [BW-1:0]    BReqBwe,
    output logic             BRspValid,
    output logic [WIDTH-1:0] BRspData,
    output logic             InitDone,
    output logic             dbg_state,
    output logic             ram_ce,
    output logic             ram_we,
    output logic [AW-1:0]    ram_addr,
    output logic [WIDTH-1:0] ram_din,
    output logic [BW-1:0]    ram_bwe,
    input  logic [WIDTH-1:0] ram_dout
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   clr_cnt;
    logic            clr_last;
    logic            last_gnt_b;   // 1 = B was granted most recently
    logic            gnt_a;
    logic            gnt_b;
    logic            rsp_pend_a;
    logic            rsp_pend_b;
    logic            init_done_q;

    assign clr_last  = (clr_cnt == AW'(DEPTH - 1));
    assign dbg_state = (state == ST_RUN);
    assign InitDone  = init_done_q;
    assign AReqReady = gnt_a;
    assign BReqReady = gnt_b;

    // Read data is only forwarded to the requester whose read was accepted last cycle.
    assign ARspValid = rsp_pend_a;
    assign BRspValid = rsp_pend_b;
    assign ARspData  = rsp_pend_a ? ram_dout : '0;
    assign BRspData  = rsp_pend_b ? ram_dout : '0;

    // State register; reset restarts the clear sweep (or goes straight to RUN).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, round-robin grant and SRAM pin mux; everything is forced idle while in reset.
    always_comb begin
        state_nxt = state;
        gnt_a     = 1'b0;
        gnt_b     = 1'b0;
        ram_ce    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_din   = '0;
        ram_bwe   = '0;
        case (state)
            ST_INIT: begin
                ram_ce   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = clr_cnt;
                ram_din  = '0;
                ram_bwe  = '1;
                if (clr_last) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                gnt_a = AReqValid && (!BReqValid || last_gnt_b);
                gnt_b = BReqValid && (!AReqValid || !last_gnt_b);
                if (gnt_a) begin
                    ram_ce   = 1'b1;
                    ram_we   = AReqWrite;
                    ram_addr = AReqAddr;
                    ram_din  = AReqData;
                    ram_bwe  = AReqBwe;
                end else if (gnt_b) begin
                    ram_ce   = 1'b1;
                    ram_we   = BReqWrite;
                    ram_addr = BReqAddr;
                    ram_din  = BReqData;
                    ram_bwe  = BReqBwe;
                end
            end
            default: state_nxt = ST_INIT;
        endcase
        if (!resetn) begin
            gnt_a   = 1'b0;
            gnt_b   = 1'b0;
            ram_ce  = 1'b0;
            ram_we  = 1'b0;
            ram_bwe = '0;
        end
    end

    // Clear counter, last-grant pointer, pending-response flags and InitDone.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clr_cnt     <= '0;
            last_gnt_b  <= 1'b1;
            rsp_pend_a  <= 1'b0;
            rsp_pend_b  <= 1'b0;
            init_done_q <= (INIT_CLEAR == 0);
        end else begin
            if (state == ST_INIT && !clr_last) begin
                clr_cnt <= clr_cnt + AW'(1);
            end
            if (gnt_a) begin
                last_gnt_b <= 1'b0;
            end else if (gnt_b) begin
                last_gnt_b <= 1'b1;
            end
            rsp_pend_a  <= gnt_a && !AReqWrite;
            rsp_pend_b  <= gnt_b && !BReqWrite;
            init_done_q <= (state_nxt == ST_RUN);
        end
    end

endmodule

// File: tb/tb_ram1p1rwbe_arbctl.sv
// Directed bench for ram1p1rwbe_arbctl with a behavioural SRAM model
// (write-then-registered-address read, byte enables).
module tb_ram1p1rwbe_arbctl;

    localparam int DEPTH = 64;
    localparam int WIDTH = 64;
    localparam int AW    = 6;
    localparam int BW    = 8;

    logic             clk;
    logic             resetn;
    logic             AReqValid, AReqReady, AReqWrite;
    logic [AW-1:0]    AReqAddr;
    logic [WIDTH-1:0] AReqData;
    logic [BW-1:0]    AReqBwe;
    logic             ARspValid;
    logic [WIDTH-1:0] ARspData;
    logic             BReqValid, BReqReady, BReqWrite;
    logic [AW-1:0]    BReqAddr;
    logic [WIDTH-1:0] BReqData;
    logic [BW-1:0]    BReqBwe;
    logic             BRspValid;
    logic [WIDTH-1:0] BRspData;
    logic             InitDone;
    logic             dbg_state;
    logic             ram_ce, ram_we;
    logic [AW-1:0]    ram_addr;
    logic [WIDTH-1:0] ram_din;
    logic [BW-1:0]    ram_bwe;
    logic [WIDTH-1:0] ram_dout;

    int n_pass  = 0;
    int n_total = 0;
    logic [WIDTH-1:0] exp_q[$];

    ram1p1rwbe_arbctl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .INIT_CLEAR(1)) dut (
        .clk(clk), .resetn(resetn),
        .AReqValid(AReqValid), .AReqReady(AReqReady), .AReqWrite(AReqWrite),
        .AReqAddr(AReqAddr), .AReqData(AReqData), .AReqBwe(AReqBwe),
        .ARspValid(ARspValid), .ARspData(ARspData),
        .BReqValid(BReqValid), .BReqReady(BReqReady), .BReqWrite(BReqWrite),
        .BReqAddr(BReqAddr), .BReqData(BReqData), .BReqBwe(BReqBwe),
        .BRspValid(BRspValid), .BRspData(BRspData),
        .InitDone(InitDone), .dbg_state(dbg_state),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_bwe(ram_bwe), .ram_dout(ram_dout)
    );

    // Clock and behavioural SRAM
    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [AW-1:0]    addr_q = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_we) begin
                for (int b = 0; b < BW; b++) begin
                    if (ram_bwe[b]) mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
                end
            end
            addr_q <= ram_addr;
        end
    end
    assign ram_dout = mem[addr_q];

    // Driver and check tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic w, input logic [AW-1:0] a,
                           input logic [WIDTH-1:0] d, input logic [BW-1:0] be);
        AReqValid = v; AReqWrite = w; AReqAddr = a; AReqData = d; AReqBwe = be;
    endtask

    task automatic drive_b(input logic v, input logic w, input logic [AW-1:0] a,
                           input logic [WIDTH-1:0] d, input logic [BW-1:0] be);
        BReqValid = v; BReqWrite = w; BReqAddr = a; BReqData = d; BReqBwe = be;
    endtask

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [WIDTH-1:0] g;
    int na, nb;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 64'hA5A5_5A5A_0000_0000 | 64'(i);
        resetn = 1'b0;
        drive_a(0, 0, '0, '0, '0);
        drive_b(0, 0, '0, '0, '0);
        #2;
        chk("rst_ce", ram_ce, 0);
        chk("rst_arsp", ARspValid, 0);
        chk("rst_brsp", BRspValid, 0);
        chk("rst_ardata", ARspData, 0);
        chk("rst_initdone", InitDone, 0);
        chk("rst_state", dbg_state, 0);

        // B posts a write during reset/INIT; it must wait for RUN
        drive_b(1, 1, 6'd10, 64'hCAFE_BABE_0BAD_F00D, 8'hFF);
        step();
        step();
        chk("rst_bready", BReqReady, 0);
        chk("rst_ce2", ram_ce, 0);
        resetn = 1'b1;
        #1;

        // Init sweep: addresses 0..63, one per cycle
        for (int k = 0; k < DEPTH; k++) begin
            chk("init_ce", ram_ce, 1);
            chk("init_we", ram_we, 1);
            chk("init_addr", ram_addr, 64'(k));
            chk("init_din", ram_din, 0);
            chk("init_bwe", ram_bwe, 8'hFF);
            chk("init_done_low", InitDone, 0);
            chk("init_bready", BReqReady, 0);
            step();
        end
        chk("init_done", InitDone, 1);
        chk("run_state", dbg_state, 1);
        chk("stall_bready", BReqReady, 1);
        chk("stall_addr", ram_addr, 10);
        chk("stall_din", ram_din, 64'hCAFE_BABE_0BAD_F00D);
        chk("stall_we", ram_we, 1);
        step();
        drive_b(0, 0, '0, '0, '0);
        #1;
        chk("bwr_norsp", BRspValid, 0);
        chk("idle_ce", ram_ce, 0);
        chk("idle_bwe", ram_bwe, 0);
        chk("idle_addr", ram_addr, 0);
        chk("idle_din", ram_din, 0);

        // Read of a cleared word
        drive_a(1, 0, 6'd5, '0, '0);
        #1;
        chk("rd5_aready", AReqReady, 1);
        chk("rd5_we", ram_we, 0);
        step();
        drive_a(0, 0, '0, '0, '0);
        #1;
        chk("rd5_arsp", ARspValid, 1);
        chk("rd5_adata", ARspData, 0);
        chk("rd5_brsp", BRspValid, 0);
        chk("rd5_bdata", BRspData, 0);
        step();
        chk("rd5_pulse", ARspValid, 0);

        // The write that stalled through INIT landed
        drive_b(1, 0, 6'd10, '0, '0);
        step();
        drive_b(0, 0, '0, '0, '0);
        #1;
        chk("rd10_brsp", BRspValid, 1);
        chk("rd10_bdata", BRspData, 64'hCAFE_BABE_0BAD_F00D);
        chk("rd10_arsp", ARspValid, 0);
        chk("rd10_adata", ARspData, 0);

        // Single requester write then back-to-back read of the same address
        drive_a(1, 1, 6'd3, 64'h1122_3344_5566_7788, 8'hFF);
        #1;
        chk("wr3_aready", AReqReady, 1);
        chk("wr3_we", ram_we, 1);
        step();
        drive_a(1, 0, 6'd3, '0, '0);
        #1;
        chk("wr3_norsp", ARspValid, 0);
        step();
        drive_a(0, 0, '0, '0, '0);
        #1;
        chk("rd3_arsp", ARspValid, 1);
        chk("rd3_adata", ARspData, 64'h1122_3344_5566_7788);
        chk("rd3_brsp", BRspValid, 0);

        // Byte enables
        drive_a(1, 1, 6'd7, '1, 8'hFF);
        step();
        drive_a(1, 1, 6'd7, '0, 8'h0F);
        #1;
        chk("be_bwe", ram_bwe, 8'h0F);
        step();
        drive_a(1, 0, 6'd7, '0, '0);
        step();
        drive_a(0, 0, '0, '0, '0);
        #1;
        chk("be_arsp", ARspValid, 1);
        chk("be_adata", ARspData, 64'hFFFF_FFFF_0000_0000);

        // B write so that B holds the last grant
        drive_b(1, 1, 6'd2, 64'h2222_0000_2222_0000, 8'hFF);
        step();
        drive_b(0, 0, '0, '0, '0);

        // Contention: A first, B next cycle
        drive_a(1, 0, 6'd1, '0, '0);
        drive_b(1, 0, 6'd2, '0, '0);
        #1;
        chk("ct_aready", AReqReady, 1);
        chk("ct_bready0", BReqReady, 0);
        chk("ct_addr_a", ram_addr, 1);
        step();
        drive_a(0, 0, '0, '0, '0);
        #1;
        chk("ct_arsp", ARspValid, 1);
        chk("ct_adata", ARspData, 0);
        chk("ct_bready1", BReqReady, 1);
        chk("ct_addr_b", ram_addr, 2);
        step();
        drive_b(0, 0, '0, '0, '0);
        #1;
        chk("ct_brsp", BRspValid, 1);
        chk("ct_bdata", BRspData, 64'h2222_0000_2222_0000);
        chk("ct_arsp_off", ARspValid, 0);

        // Sustained contention: six requests each, grants must alternate A,B,...
        for (int i = 0; i < 12; i++) exp_q.push_back(64'(i % 2));
        na = 0;
        nb = 0;
        drive_a(1, 0, 6'd3, '0, '0);
        drive_b(1, 0, 6'd7, '0, '0);
        for (int i = 0; i < 12; i++) begin
            #1;
            g = exp_q.pop_front();
            chk("alt_gnt", {AReqReady, BReqReady}, (g == 0) ? 64'd2 : 64'd1);
            step();
            if (g == 0) na++; else nb++;
            if (na == 6) AReqValid = 1'b0;
            if (nb == 6) BReqValid = 1'b0;
            #1;
            chk("alt_rsp", {ARspValid, BRspValid}, (g == 0) ? 64'd2 : 64'd1);
            if (g == 0) chk("alt_adata", ARspData, 64'h1122_3344_5566_7788);
            else        chk("alt_bdata", BRspData, 64'hFFFF_FFFF_0000_0000);
        end

        // Reset right after an A read is accepted
        drive_a(1, 0, 6'd3, '0, '0);
        step();
        resetn = 1'b0;
        drive_a(0, 0, '0, '0, '0);
        #1;
        chk("mr_arsp", ARspValid, 0);
        chk("mr_ce", ram_ce, 0);
        chk("mr_initdone", InitDone, 0);
        step();
        resetn = 1'b1;
        #1;
        chk("mr_addr0", ram_addr, 0);
        chk("mr_ce_init", ram_ce, 1);
        chk("mr_arsp2", ARspValid, 0);
        step();
        chk("mr_addr1", ram_addr, 1);
        repeat (DEPTH - 1) step();
        chk("mr_initdone2", InitDone, 1);
        drive_a(1, 0, 6'd3, '0, '0);
        step();
        drive_a(1, 0, 6'd10, '0, '0);
        #1;
        chk("mr_rd3_rsp", ARspValid, 1);
        chk("mr_rd3_data", ARspData, 0);
        step();
        drive_a(0, 0, '0, '0, '0);
        #1;
        chk("mr_rd10_data", ARspData, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
